// File: rtl/usb_fifo_arb_pkg.sv
// Shared state type and constants for the USB endpoint FIFO read-port arbiter.
package usb_fifo_arb_pkg;

    localparam int MAX_NUM_REQ = 4;
    localparam int PTR_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SETTLE,
        FLUSH
    } arb_state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] onehot);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (onehot[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/usb_fifo_rd_arb_if.sv
// Signals between the FIFO read-port arbiter, its requesters and the endpoint FIFO read side.
interface usb_fifo_rd_arb_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]    rdReq;
    logic [NUM_REQ-1:0]    rdAck;
    logic [FIFO_WIDTH-1:0] rdData;
    logic                  rdUnderflow;
    logic                  flushReq;
    logic                  fifoREn;
    logic                  fifoForceEmpty;
    logic [FIFO_WIDTH-1:0] fifoDataOut;
    logic                  fifoEmpty;
    logic                  busy;

    modport slave (
        input  rdReq, flushReq, fifoDataOut, fifoEmpty,
        output rdAck, rdData, rdUnderflow, fifoREn, fifoForceEmpty, busy
    );

    modport master (
        output rdReq, flushReq, fifoDataOut, fifoEmpty,
        input  rdAck, rdData, rdUnderflow, fifoREn, fifoForceEmpty, busy
    );
endinterface

// File: rtl/usb_rr_pick.sv
// Combinational one-hot grant picker; round-robin from ptr when USB_FIFO_RD_ARB_RR_EN
// is defined, otherwise a plain lowest-index priority encoder.
module usb_rr_pick
    import usb_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef USB_FIFO_RD_ARB_RR_EN
    input  logic [PTR_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] grant
);

`ifdef USB_FIFO_RD_ARB_RR_EN
    logic found;

    // Visit requesters in order ptr, ptr+1, ... and take the first one asserted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == (int'(ptr) + i) % NUM_REQ && !found && req[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/usb_fifo_rd_arb.sv
// USB endpoint FIFO read-port arbiter: shapes rising-edge fifoREn pulses, captures registered
// FIFO data and sequences flushes. Define USB_FIFO_RD_ARB_RR_EN for round-robin arbitration.
module usb_fifo_rd_arb
    import usb_fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic             clk,
    input  logic             rst,
    usb_fifo_rd_arb_if.slave bus
);

    arb_state_t            state, state_n;
    logic [NUM_REQ-1:0]    grant, grant_n, pick, ack_n, rd_ack;
    logic                  under_n, load_data;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic                  rd_underflow, fifo_ren, force_empty, busy_q;

`ifdef USB_FIFO_RD_ARB_RR_EN
    logic [PTR_W-1:0] ptr;

    usb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.rdReq),
        .ptr   (ptr),
        .grant (pick)
    );

    // Every ack, underflow included, hands priority to the requester after the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (ack_n != '0) begin
            ptr <= PTR_W'((int'(onehot_to_idx(MAX_NUM_REQ'(ack_n))) + 1) % NUM_REQ);
        end
    end
`else
    usb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.rdReq),
        .grant (pick)
    );
`endif

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        ack_n     = '0;
        under_n   = 1'b0;
        load_data = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick != '0) begin
                    grant_n = pick;
                    if (bus.fifoEmpty) begin
                        ack_n   = pick;
                        under_n = 1'b1;
                        state_n = SETTLE;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ:    state_n = CAPTURE;
            CAPTURE: begin
                ack_n     = grant;
                load_data = 1'b1;
                state_n   = SETTLE;
            end
            SETTLE:  state_n = IDLE;
            FLUSH:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A flush aborts whatever is in flight; the popped word is dropped and no ack is given.
        if (bus.flushReq) begin
            state_n   = FLUSH;
            ack_n     = '0;
            under_n   = 1'b0;
            load_data = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            rd_ack       <= '0;
            rd_data      <= '0;
            rd_underflow <= 1'b0;
            fifo_ren     <= 1'b0;
            force_empty  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            rd_ack       <= ack_n;
            rd_underflow <= under_n;
            fifo_ren     <= (state_n == READ);
            force_empty  <= (state_n == FLUSH);
            busy_q       <= (state_n != IDLE);
            if (load_data) rd_data <= bus.fifoDataOut;
        end
    end

    assign bus.rdAck          = rd_ack;
    assign bus.rdData         = rd_data;
    assign bus.rdUnderflow    = rd_underflow;
    assign bus.fifoREn        = fifo_ren;
    assign bus.fifoForceEmpty = force_empty;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_usb_fifo_rd_arb.sv
// Bench for usb_fifo_rd_arb: vector table, hand-written corner sequences and a randomized
// run checked against a transaction-level model. Honours USB_FIFO_RD_ARB_RR_EN like the RTL.
module tb_usb_fifo_rd_arb;

    localparam int W    = 8;
    localparam int NREQ = 2;
`ifdef USB_FIFO_RD_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]    preload;
        logic            hasData;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] expAck;
        logic [W-1:0]    expData;
        logic            expUnder;
        int              expLat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    usb_fifo_rd_arb_if #(.FIFO_WIDTH(W), .NUM_REQ(NREQ)) bus ();

    usb_fifo_rd_arb #(.FIFO_WIDTH(W), .NUM_REQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Endpoint FIFO model: pops on a rising edge of fifoREn, registered data and empty flag.
    logic [W-1:0] fifoQ [$];
    logic [W-1:0] fifoDout   = '0;
    logic         fifoEmptyR = 1'b1;
    logic         renPrev    = 1'b0;

    always @(posedge clk) begin
        if (bus.fifoForceEmpty) fifoQ.delete();
        else if (bus.fifoREn && !renPrev && fifoQ.size() != 0) fifoDout <= fifoQ.pop_front();
        renPrev    <= bus.fifoREn;
        fifoEmptyR <= (fifoQ.size() == 0);
    end

    assign bus.fifoDataOut = fifoDout;
    assign bus.fifoEmpty   = fifoEmptyR;

    logic [W-1:0]    refQ [$];
    int              ptrModel;
    logic [NREQ-1:0] reqHist [0:1023];
    logic            renHist [0:1023];
    vec_t            tbl [7];
    logic [NREQ-1:0] gotAck [3];
    logic [W-1:0]    gotData [3];
    logic            gotUnder [3];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int expWinner(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic doReset();
        bus.rdReq    = '0;
        bus.flushReq = 1'b0;
        rst          = 1'b1;
        fifoQ.delete();
        refQ.delete();
        ptrModel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload(input int n);
        logic [W-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = W'($urandom);
            fifoQ.push_back(v);
            refQ.push_back(v);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int              ackCyc, renCyc, renCnt;
        logic [NREQ-1:0] ack;
        logic [W-1:0]    data;
        logic            under, busyAfter;
        ackCyc = -1; renCyc = -1; renCnt = 0;
        ack = '0; data = '0; under = 1'b0; busyAfter = 1'b1;
        if (v.hasData) begin
            fifoQ.push_back(v.preload);
            @(negedge clk);
            @(negedge clk);
        end
        bus.rdReq = v.req;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.fifoREn) begin
                renCnt++;
                renCyc = c;
            end
            if (c == 1) checkOutput($sformatf("vec%0d busyC1", idx), bus.busy, 1);
            if (ackCyc >= 0 && c == ackCyc + 1) busyAfter = bus.busy;
            if (bus.rdAck != '0 && ackCyc < 0) begin
                ackCyc    = c;
                ack       = bus.rdAck;
                data      = bus.rdData;
                under     = bus.rdUnderflow;
                bus.rdReq = '0;
            end
        end
        checkOutput($sformatf("vec%0d ack", idx), ack, v.expAck);
        checkOutput($sformatf("vec%0d data", idx), data, v.expData);
        checkOutput($sformatf("vec%0d underflow", idx), under, v.expUnder);
        checkOutput($sformatf("vec%0d latency", idx), ackCyc, v.expLat);
        checkOutput($sformatf("vec%0d renCount", idx), renCnt, v.hasData ? 1 : 0);
        checkOutput($sformatf("vec%0d renCycle", idx), renCyc, v.hasData ? 1 : -1);
        checkOutput($sformatf("vec%0d busyAfterAck", idx), busyAfter, 0);
    endtask

    // Requesters hold rdReq until acked; each ack is checked against the arbitration rule,
    // the FIFO contents in write order and the read-enable spacing.
    task automatic runModel(input int raiseCycles, input logic [NREQ-1:0] mask, input int pct);
        logic [NREQ-1:0] pending, acked;
        logic            under, recent;
        int              dcyc, w;
        pending = '0;
        for (int cyc = 0; cyc < raiseCycles + 40; cyc++) begin
            @(negedge clk);
            renHist[cyc] = bus.fifoREn;
            if (bus.fifoREn) begin
                recent = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    if (cyc >= k && renHist[cyc-k]) recent = 1'b1;
                end
                checkOutput("renSpacing", recent, 0);
            end
            acked = '0;
            if (bus.rdAck != '0) begin
                under = bus.rdUnderflow;
                dcyc  = under ? cyc - 1 : cyc - 3;
                w     = (dcyc >= 0) ? expWinner(reqHist[dcyc], ptrModel) : -1;
                checkOutput("ackGrant", bus.rdAck, (w < 0) ? 0 : (1 << w));
                checkOutput("ackKind", under, refQ.size() == 0);
                if (!under && refQ.size() != 0) begin
                    checkOutput("ackData", bus.rdData, refQ.pop_front());
                    checkOutput("renBeforeAck", (cyc >= 2) ? renHist[cyc-2] : 1'b0, 1);
                end
                if (w >= 0) ptrModel = RR_BUILD ? (w + 1) % NREQ : 0;
                acked   = bus.rdAck;
                pending = pending & ~bus.rdAck;
            end
            if (cyc < raiseCycles) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (mask[i] && !pending[i] && !acked[i] && $urandom_range(99) < pct) pending[i] = 1'b1;
                end
            end
            bus.rdReq    = pending;
            reqHist[cyc] = pending;
            if (cyc >= raiseCycles && pending == '0 && !bus.busy) break;
        end
        checkOutput("drained", pending, 0);
    endtask

    initial begin
        int              c0, ackCyc, forceCnt, renCnt, ackCnt, nAck;
        logic [NREQ-1:0] ack;
        logic            under;
        logic [NREQ-1:0] expA [3];

        tbl[0] = '{8'hA5, 1'b1, 2'b01, 2'b01, 8'hA5, 1'b0, 3};
        tbl[1] = '{8'h00, 1'b0, 2'b10, 2'b10, 8'hA5, 1'b1, 1};
        tbl[2] = '{8'h3C, 1'b1, 2'b11, 2'b01, 8'h3C, 1'b0, 3};
        tbl[3] = '{8'h5A, 1'b1, 2'b11, RR_BUILD ? 2'b10 : 2'b01, 8'h5A, 1'b0, 3};
        tbl[4] = '{8'h00, 1'b0, 2'b11, 2'b01, 8'h5A, 1'b1, 1};
        tbl[5] = '{8'hC3, 1'b1, 2'b10, 2'b10, 8'hC3, 1'b0, 3};
        tbl[6] = '{8'h00, 1'b0, 2'b01, 2'b01, 8'hC3, 1'b1, 1};

        bus.rdReq    = '0;
        bus.flushReq = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetAck", bus.rdAck, 0);
        checkOutput("resetData", bus.rdData, 0);
        checkOutput("resetUnder", bus.rdUnderflow, 0);
        checkOutput("resetREn", bus.fifoREn, 0);
        checkOutput("resetForce", bus.fifoForceEmpty, 0);
        checkOutput("resetBusy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) applyStimulus(tbl[v], v);

        // Both requesters asking continuously against a two-word FIFO.
        doReset();
        fifoQ.push_back(8'h11);
        fifoQ.push_back(8'h22);
        @(negedge clk);
        @(negedge clk);
        bus.rdReq = 2'b11;
        nAck = 0;
        for (int c = 1; c <= 20 && nAck < 3; c++) begin
            @(negedge clk);
            if (bus.rdAck != '0) begin
                gotAck[nAck]   = bus.rdAck;
                gotData[nAck]  = bus.rdData;
                gotUnder[nAck] = bus.rdUnderflow;
                nAck++;
                bus.rdReq = bus.rdReq & ~bus.rdAck;
            end else begin
                bus.rdReq = 2'b11;
            end
        end
        bus.rdReq = '0;
        repeat (3) @(negedge clk);
        expA[0] = 2'b01;
        expA[1] = RR_BUILD ? 2'b10 : 2'b01;
        expA[2] = 2'b01;
        checkOutput("contAckCount", nAck, 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("contAck%0d", i), gotAck[i], expA[i]);
            checkOutput($sformatf("contUnder%0d", i), gotUnder[i], (i == 2) ? 1 : 0);
            checkOutput($sformatf("contData%0d", i), gotData[i], (i == 0) ? 8'h11 : 8'h22);
        end

        // Reset asserted while the arbiter is capturing data.
        fifoQ.push_back(8'h42);
        @(negedge clk);
        @(negedge clk);
        bus.rdReq = 2'b01;
        @(negedge clk);
        checkOutput("rstSeqREnC1", bus.fifoREn, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.rdReq = '0;
        checkOutput("rstSeqAck", bus.rdAck, 0);
        checkOutput("rstSeqData", bus.rdData, 0);
        checkOutput("rstSeqUnder", bus.rdUnderflow, 0);
        checkOutput("rstSeqREn", bus.fifoREn, 0);
        checkOutput("rstSeqForce", bus.fifoForceEmpty, 0);
        checkOutput("rstSeqBusy", bus.busy, 0);
        renCnt = 0;
        ackCnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.fifoREn) renCnt++;
            if (bus.rdAck != '0) ackCnt++;
        end
        checkOutput("rstSeqLateREn", renCnt, 0);
        checkOutput("rstSeqLateAck", ackCnt, 0);

        // Flush arriving in the READ cycle.
        doReset();
        fifoQ.push_back(8'h77);
        @(negedge clk);
        @(negedge clk);
        bus.rdReq = 2'b01;
        @(negedge clk);
        checkOutput("flushReadREn", bus.fifoREn, 1);
        bus.flushReq = 1'b1;
        @(negedge clk);
        bus.flushReq = 1'b0;
        checkOutput("flushForce", bus.fifoForceEmpty, 1);
        checkOutput("flushNoAck", bus.rdAck, 0);
        forceCnt = 0; renCnt = 0; ackCyc = -1; ack = '0; under = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            if (bus.fifoForceEmpty) forceCnt++;
            if (bus.fifoREn) renCnt++;
            if (bus.rdAck != '0 && ackCyc < 0) begin
                ackCyc    = c;
                ack       = bus.rdAck;
                under     = bus.rdUnderflow;
                bus.rdReq = '0;
            end
        end
        checkOutput("flushForceOnce", forceCnt, 0);
        checkOutput("flushNoRead", renCnt, 0);
        checkOutput("flushAckCycle", ackCyc, 4);
        checkOutput("flushAck", ack, 2'b01);
        checkOutput("flushAckUnder", under, 1);

        // Sixteen-word stream to one requester.
        doReset();
        preload(16);
        runModel(64, 2'b01, 100);
        checkOutput("streamConsumed", refQ.size(), 0);

        // Randomized rounds: random FIFO fill, random request arrivals.
        doReset();
        for (int r = 0; r < 8; r++) begin
            preload($urandom_range(0, 6));
            runModel(40, 2'b11, 35);
        end

        c0 = checks;
        if (c0 == 0) $display("[TB] no checks executed");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
